// File: rtl/dt_res_arbiter.sv
// Serialises the distance-transform engine (port 0) and the host dump/preload port (port 1)
// onto the single result-RAM interface: round-robin, optional burst lock, bounded tenure.
module dt_res_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              lock0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              lock1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              res_rd_q, res_rd_d;
  logic              res_wr_q, res_wr_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_do_q, res_do_d;
  logic              rd_owner_q, rd_owner_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              own1;
  logic              accept;
  logic              cur_req;
  logic              oth_req;
  logic              cur_lock;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [8:0]        cnt_sum;
  logic              at_max;

  always_comb begin
    own1      = (state_q == OWN1);
    cur_req   = own1 ? req1   : req0;
    oth_req   = own1 ? req0   : req1;
    cur_lock  = own1 ? lock1  : lock0;
    cur_wr    = own1 ? wr1    : wr0;
    cur_addr  = own1 ? addr1  : addr0;
    cur_wdata = own1 ? wdata1 : wdata0;
    accept    = ((state_q == OWN0) && req0) || ((state_q == OWN1) && req1);
    // Count includes this cycle's accept so the MAX_BURST-th transfer is still honoured.
    cnt_sum   = {1'b0, burst_cnt_q} + {8'd0, accept};
    at_max    = (cnt_sum >= 9'(MAX_BURST));
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = 8'd0;
        if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
        else if (req0)    state_d = OWN0;
        else if (req1)    state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (oth_req && (!cur_lock || at_max)) begin
          state_d     = own1 ? OWN0 : OWN1;
          last_d      = own1;
          burst_cnt_d = 8'd0;
        end else if (!oth_req && !cur_req && !cur_lock) begin
          state_d     = IDLE;
          last_d      = own1;
          burst_cnt_d = 8'd0;
        end else if (cur_lock && at_max) begin
          burst_cnt_d = 8'd0;
        end else begin
          burst_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // The issuing port is remembered with the strobe so the return survives a handover.
  always_comb begin
    res_rd_d   = accept && !cur_wr;
    res_wr_d   = accept && cur_wr;
    res_addr_d = accept ? cur_addr  : res_addr_q;
    res_do_d   = accept ? cur_wdata : res_do_q;
    rd_owner_d = accept ? own1      : rd_owner_q;
    rvalid0_d  = res_rd_q && !rd_owner_q;
    rvalid1_d  = res_rd_q && rd_owner_q;
    rdata0_d   = rvalid0_d ? res_di : rdata0_q;
    rdata1_d   = rvalid1_d ? res_di : rdata1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= 8'd0;
      res_rd_q    <= 1'b0;
      res_wr_q    <= 1'b0;
      res_addr_q  <= '0;
      res_do_q    <= '0;
      rd_owner_q  <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      res_rd_q    <= res_rd_d;
      res_wr_q    <= res_wr_d;
      res_addr_q  <= res_addr_d;
      res_do_q    <= res_do_d;
      rd_owner_q  <= rd_owner_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign gnt0     = (state_q == OWN0);
  assign gnt1     = (state_q == OWN1);
  assign res_rd   = res_rd_q;
  assign res_wr   = res_wr_q;
  assign res_addr = res_addr_q;
  assign res_do   = res_do_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dt_res_arbiter.sv
// Scoreboard bench for dt_res_arbiter: a behavioural arbitration model queues per-cycle
// expectations, a negedge monitor compares bus, grants and read returns against them.
module tb_dt_res_arbiter;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, lock0, wr0, req1, lock1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          res_rd, res_wr;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_do, res_di;

  always #5 clk = ~clk;

  dt_res_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do),
    .res_di(res_di)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 128) return 8'd5;
    return 8'((i * 37) ^ (i >> 6));
  endfunction

  // Result RAM: combinational read, write on the edge that ends a res_wr cycle.
  logic [DW-1:0] ram [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (res_wr) ram[res_addr] <= res_do;
    end
  end
  assign res_di = ram[res_addr];

  typedef struct packed {
    logic [1:0]    own;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
  } exp_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  exp_t cyc_q[$];
  ret_t ret_q0[$];
  ret_t ret_q1[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Reference model: who owns the RAM, who went last, how long the tenure has run.
  int            m_owner = -1;
  int            m_last  = 1;
  int            m_cnt   = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_do    = '0;
  logic [DW-1:0] ref_mem [0:16383];
  bit            rq [2];
  bit            lk [2];
  bit            wv [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  initial begin
    exp_t e;
    ret_t r;
    int   x, o, acc;
    bit   reached;
    for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (!reset) begin
        m_owner = -1; m_last = 1; m_cnt = 0; m_addr = '0; m_do = '0;
      end else begin
        rq[0] = req0;  rq[1] = req1;  lk[0] = lock0;  lk[1] = lock1;
        wv[0] = wr0;   wv[1] = wr1;   ad[0] = addr0;  ad[1] = addr1;
        wd[0] = wdata0; wd[1] = wdata1;
        if (m_owner < 0) begin
          if (rq[0] && rq[1]) m_owner = 1 - m_last;
          else if (rq[0])     m_owner = 0;
          else if (rq[1])     m_owner = 1;
          m_cnt = 0;
        end else begin
          x = m_owner;
          o = 1 - x;
          acc = rq[x] ? 1 : 0;
          if (acc == 1) begin
            m_addr = ad[x];
            m_do   = wd[x];
            if (wv[x]) begin
              e.wr = 1'b1;
              ref_mem[ad[x]] = wd[x];
            end else begin
              e.rd   = 1'b1;
              r.due  = cyc + 1;
              r.data = ref_mem[ad[x]];
              if (x == 0) ret_q0.push_back(r);
              else        ret_q1.push_back(r);
            end
          end
          reached = (m_cnt + acc) >= MB;
          if (rq[o] && (!lk[x] || reached)) begin
            m_owner = o; m_last = x; m_cnt = 0;
          end else if (!rq[o] && !rq[x] && !lk[x]) begin
            m_owner = -1; m_last = x; m_cnt = 0;
          end else if (lk[x] && reached) begin
            m_cnt = 0;
          end else begin
            m_cnt = (m_cnt + acc > 255) ? 255 : m_cnt + acc;
          end
        end
        e.own  = 2'(m_owner + 1);
        e.addr = m_addr;
        e.dat  = m_do;
      end
      cyc_q.push_back(e);
    end
  end

  // Monitor: one expectation per cycle, read returns matched by due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc_q.delete();
        ret_q0.delete();
        ret_q1.delete();
        chk("reset_outputs",
            64'({gnt0, gnt1, res_rd, res_wr, res_addr, res_do, rvalid0, rvalid1, rdata0, rdata1}),
            64'd0);
      end else begin
        if (cyc_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL exp_queue at cycle %0d: got empty queue, expected an entry", cyc);
        end else begin
          e = cyc_q.pop_front();
          chk("gnt0", 64'(gnt0), 64'(e.own == 2'd1));
          chk("gnt1", 64'(gnt1), 64'(e.own == 2'd2));
          chk("res_rd", 64'(res_rd), 64'(e.rd));
          chk("res_wr", 64'(res_wr), 64'(e.wr));
          chk("res_addr", 64'(res_addr), 64'(e.addr));
          chk("res_do", 64'(res_do), 64'(e.dat));
          if (e.rd || e.wr)
            $display("cycle %0d: %s addr=%0d data=0x%02h gnt0=%0b gnt1=%0b",
                     cyc, e.wr ? "WRITE" : "READ ", e.addr, e.wr ? e.dat : res_di, gnt0, gnt1);
        end
        while (ret_q0.size() > 0 && ret_q0[0].due < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL rvalid0_missed at cycle %0d: got none, expected return due %0d",
                   cyc, ret_q0[0].due);
          void'(ret_q0.pop_front());
        end
        if (ret_q0.size() > 0 && ret_q0[0].due == cyc) begin
          chk("rvalid0", 64'(rvalid0), 64'd1);
          chk("rdata0", 64'(rdata0), 64'(ret_q0[0].data));
          $display("cycle %0d: RET0 data=0x%02h", cyc, rdata0);
          void'(ret_q0.pop_front());
        end else begin
          chk("rvalid0_idle", 64'(rvalid0), 64'd0);
        end
        while (ret_q1.size() > 0 && ret_q1[0].due < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL rvalid1_missed at cycle %0d: got none, expected return due %0d",
                   cyc, ret_q1[0].due);
          void'(ret_q1.pop_front());
        end
        if (ret_q1.size() > 0 && ret_q1[0].due == cyc) begin
          chk("rvalid1", 64'(rvalid1), 64'd1);
          chk("rdata1", 64'(rdata1), 64'(ret_q1[0].data));
          $display("cycle %0d: RET1 data=0x%02h", cyc, rdata1);
          void'(ret_q1.pop_front());
        end else begin
          chk("rvalid1_idle", 64'(rvalid1), 64'd0);
        end
      end
    end
  end

  task automatic drive(input bit r0, input bit l0, input bit w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input bit r1, input bit l1, input bit w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; lock0 = l0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; wr1 = w1; addr1 = a1; wdata1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int p;
    p = $urandom_range(0, 17);
    if (p < 16)  return AW'(p);
    if (p == 16) return 14'd16383;
    return 14'd128;
  endfunction

  task automatic drive_rand(input int p_req, input int p_lock);
    drive($urandom_range(0, 99) < p_req, $urandom_range(0, 99) < p_lock, 1'($urandom_range(0, 1)),
          pick_addr(), 8'($urandom),
          $urandom_range(0, 99) < p_req, $urandom_range(0, 99) < p_lock, 1'($urandom_range(0, 1)),
          pick_addr(), 8'($urandom));
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; lock0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; lock1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    drive_idle(3);
    reset = 1'b1;
    drive_idle(1);

    // Single read of address 128 by requester 0.
    drive(1, 0, 0, 14'd128, 8'd0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 14'd128, 8'd0, 0, 0, 0, '0, '0);
    drive_idle(4);

    // Both requesting single transfers: grants alternate.
    for (int i = 0; i < 8; i++) drive(1, 0, 0, 14'd10, 8'd0, 1, 0, 0, 14'd20, 8'd0);
    drive_idle(4);

    // Locked burst with a contender: handover forced after MAX_BURST transfers.
    drive(1, 1, 0, 14'd200, 8'd0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 24; i++)
      drive(1, 1, i[0], AW'(200 + i), 8'(i), 1, 0, 0, 14'd300, 8'd0);
    drive_idle(4);

    // Locked burst with no contender: tenure continues past MAX_BURST without gaps.
    for (int i = 0; i < 42; i++) drive(1, 1, 0, AW'(400 + i), 8'd0, 0, 0, 0, '0, '0);
    drive_idle(4);

    // Requester 1 writes 0xAA to the top address, then reads it back.
    drive(0, 0, 0, '0, '0, 1, 0, 1, 14'd16383, 8'hAA);
    drive(0, 0, 0, '0, '0, 1, 0, 1, 14'd16383, 8'hAA);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 14'd16383, 8'h00);
    drive_idle(4);

    // Reset lands in the cycle the read strobe is out; the read must never return.
    drive(1, 0, 0, 14'd128, 8'd0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 14'd128, 8'd0, 0, 0, 0, '0, '0);
    reset = 1'b0;
    drive_idle(2);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 14'd5, 8'd0, 1, 0, 0, 14'd6, 8'd0);
    drive_idle(3);

    // Random traffic, then random traffic with occasional reset pulses.
    for (int i = 0; i < 1200; i++) drive_rand(60, 30);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        drive_rand(70, 40);
        reset = 1'b1;
      end else begin
        drive_rand(70, 40);
      end
    end
    drive_idle(6);

    @(negedge clk);
    #1;
    chk("final_exp_queue_empty", 64'(cyc_q.size()), 64'd0);
    chk("final_ret0_queue_empty", 64'(ret_q0.size()), 64'd0);
    chk("final_ret1_queue_empty", 64'(ret_q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt_res_arbiter.md
Name: dt_res_arbiter

Overview:
- Two-port arbiter for the shared 16384x8 result RAM.
- Requester 0 is the distance-transform engine; requester 1 is the host dump/preload port, which reads results back or preloads images.
- The block serialises both requesters onto the single res_rd/res_wr/res_addr/res_do/res_di interface.
- Policy is round-robin with optional burst lock and a bounded burst length, so neither side can starve the other.

Parameters:
ADDR_W, 14, RAM address width (16384 words)
DATA_W, 8, RAM data width
MAX_BURST, 16, max accepted transfers per tenure while the other side waits (2..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
req0  in  1  requester 0 transfer request
lock0  in  1  requester 0 asks to keep grant after current transfer
wr0  in  1  1=write, 0=read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 owns RAM this cycle (registered)
rvalid0  out  1  read data valid pulse for requester 0
rdata0  out  DATA_W  read data for requester 0
req1, lock1, wr1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
res_rd  out  1  RAM read strobe
res_wr  out  1  RAM write strobe
res_addr  out  ADDR_W  RAM address
res_do  out  DATA_W  RAM write data
res_di  in  DATA_W  RAM read data, valid in same cycle as res_rd/res_addr

Behaviour:
- Reset (reset=0, any time): state=IDLE, last=1 (requester 0 preferred first), burst_cnt=0. All outputs 0: gnt0/1, res_rd, res_wr, res_addr, res_do, rvalid0/1, rdata0/1. In-flight reads are dropped; no rvalid after reset.
- FSM states: IDLE, OWN0, OWN1. gnt0=1 exactly in OWN0, gnt1=1 exactly in OWN1; never both.
- IDLE:
  - Only reqX -> OWNX.
  - Both -> OWN of the requester not equal to last.
  - None -> stay IDLE.
  - Grant appears the cycle after req is first seen (1-cycle arbitration latency).
- Accept: cycle where gntX=1 and reqX=1. At the next edge res_addr<=addrX, res_do<=wdataX, res_wr<=wrX, res_rd<=~wrX.
- Strobes are single-cycle per accept; back-to-back accepts give continuous strobes.
- No accept: res_rd=res_wr=0; res_addr/res_do hold last value.
- Read return: edge after res_rd=1, rdataX<=res_di and rvalidX<=1 for one cycle, routed to the requester that issued it.
  - Accept-to-rvalid latency is 2 cycles.
  - Routing survives a grant change in between.
- burst_cnt: increments on each accept in OWNX (8-bit, saturating); cleared on any state change.
- OWNX exit rules, evaluated every cycle; the transition takes effect at the next edge:
  - Other req=1 and (lockX=0 or burst_cnt+accept reaches MAX_BURST) -> OWN(other), last<=X. Forced handover overrides lock.
  - Other req=0 and reqX=0 and lockX=0 -> IDLE, last<=X.
  - Otherwise stay. With lockX=1 and other idle, burst_cnt is cleared at MAX_BURST and the tenure continues.
- Handover is direct OWN0<->OWN1 with no idle bubble. The accept in the final OWNX cycle is honoured.
- reqX dropped while lockX=1 and other idle: stay OWNX, no strobes.
- Writes and reads from different requesters are never reordered relative to their accept order.

Test Plan:
- Single read: reset release, req0=1 wr0=0 addr0=14'd128, RAM holds 8'd5 -> gnt0 at cycle 1; res_rd=1 res_addr=128 at cycle 2; rvalid0=1 rdata0=5 at cycle 3; rvalid1 stays 0.
- Simultaneous request after reset: req0=req1=1, no lock, single transfers -> grants alternate 0,1,0,1 each cycle; res_addr alternates addr0/addr1; last toggles.
- Lock with forced handover: MAX_BURST=16, lock0=1, req0 held, req1 raised at burst start -> exactly 16 requester-0 strobes, then gnt1; lock0 is ignored.
- Lock with no contender: lock0=1, req1=0 for 40 transfers -> gnt0 continuous, burst_cnt wraps at 16, no gap in res_rd.
- Write-then-read: requester 1 writes 8'hAA to 14'd16383, then reads it back -> res_wr=1 res_do=AA at one cycle; 2 cycles after the read accept, rvalid1=1 rdata1=AA.
- Reset mid-read: reset=0 asserted the cycle res_rd=1 -> next cycle all outputs 0; after release no rvalid pulse; state IDLE; requester 0 wins the first contended grant.
